// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state encoding and default width.
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/full_add_bit.sv
// One-bit full adder assembled from two half-adder cells and an OR gate for the carry.
module full_add_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;
    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first addition through one shared full-add cell.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-2:0] res_sh_reg;
    logic [WIDTH-1:0] res_next;
    logic             carry_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             fa_s;
    logic             fa_co;

    full_add_bit u_fa (
        .a   (a_sh_reg[0]),
        .b   (b_sh_reg[0]),
        .cin (carry_reg),
        .s   (fa_s),
        .co  (fa_co)
    );

    // The newest sum bit enters at the MSB; only the upper WIDTH-1 bits need storing.
    assign res_next = {fa_s, res_sh_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)             state_next = ST_RUN;
            ST_RUN:  if (count_reg == LAST_BIT) state_next = ST_DONE;
            ST_DONE: if (out_ready)            state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
        busy      = (state_reg == ST_RUN) || (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            count_reg  <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        count_reg <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        // Two's-complement subtract: a + ~b + 1.
                        b_sh_reg  <= sub ? ~b : b;
                        carry_reg <= sub;
`else
                        b_sh_reg  <= b;
                        carry_reg <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_sh_reg <= res_next[WIDTH-1:1];
                    carry_reg  <= fa_co;
                    if (count_reg == LAST_BIT) begin
                        sum_reg  <= res_next;
                        cout_reg <= fa_co;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
